phrase_writer: RTL and testbench

Command-driven text writer placed directly upstream of the phrase character RAM. It accepts character, cursor and clear commands from the console controller and converts them into single-cycle RAM write strobes (address_wr, data_in, write_enable, enable_ram). It keeps the text cursor as row/column, auto-advances the cursor with wrap-around, and can fill the whole screen with one character.

---
 rtl/phrase_writer.sv | 169 ++++++++++++++++
 tb/tb_phrase_writer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/phrase_writer.sv
// phrase_writer: turns console commands (write char, set cursor, clear) into
// single-cycle write strobes for the phrase character RAM, tracking a
// row/column text cursor with wrap-around.
// Optional feature macro: PHRASE_NEWLINE_EN (8'h0A moves the cursor to the
// start of the next row instead of being written).
module phrase_writer #(
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 60,
    parameter int unsigned COL_W = 7,
    parameter int unsigned ROW_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [12:0]      cmd_data,
    output logic             cmd_ready,
    output logic             enable_ram,
    output logic             write_enable,
    output logic [12:0]      address_wr,
    output logic [7:0]       data_in,
    output logic             busy,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col
);

    localparam int unsigned ADDR_W = 13;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e            state, state_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        data_d;
    logic [ROW_W-1:0]  row_d;
    logic [COL_W-1:0]  col_d;
    logic [7:0]        fill_q, fill_d;
    logic [ADDR_W-1:0] clr_q, clr_d;

    logic              accept;
    logic [ADDR_W-1:0] cur_addr;
    logic [ROW_W-1:0]  row_inc;
    logic [ROW_W-1:0]  set_row;
    logic [COL_W-1:0]  set_col;

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state == S_CLEAR);
    assign accept    = cmd_valid && cmd_ready;
    assign cur_addr  = ADDR_W'(cursor_row * COLS) + ADDR_W'(cursor_col);
    assign row_inc   = (cursor_row == LAST_ROW) ? '0 : cursor_row + 1'b1;
    assign set_row   = cmd_data[COL_W +: ROW_W];
    assign set_col   = cmd_data[COL_W-1:0];

    // Next-state and next-output decode for command handling and the clear sweep
    always_comb begin
        state_d = state;
        we_d    = 1'b0;
        addr_d  = address_wr;
        data_d  = data_in;
        row_d   = cursor_row;
        col_d   = cursor_col;
        fill_d  = fill_q;
        clr_d   = clr_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op_e'(cmd_op))
                        OP_WRITE: begin
`ifdef PHRASE_NEWLINE_EN
                            if (cmd_data[7:0] == 8'h0A) begin
                                col_d = '0;
                                row_d = row_inc;
                            end else begin
`else
                            begin
`endif
                                we_d   = 1'b1;
                                addr_d = cur_addr;
                                data_d = cmd_data[7:0];
                                if (cursor_col == LAST_COL) begin
                                    col_d = '0;
                                    row_d = row_inc;
                                end else begin
                                    col_d = cursor_col + 1'b1;
                                end
                            end
                        end
                        OP_SET: begin
                            if ((32'(set_row) < ROWS) && (32'(set_col) < COLS)) begin
                                row_d = set_row;
                                col_d = set_col;
                            end
                        end
                        OP_CLEAR: begin
                            // Address 0 is issued on the accepting edge; the
                            // sweep counter starts at 1.
                            fill_d  = cmd_data[7:0];
                            we_d    = 1'b1;
                            addr_d  = '0;
                            data_d  = cmd_data[7:0];
                            clr_d   = ADDR_W'(1);
                            state_d = S_CLEAR;
                        end
                        default: ;
                    endcase
                end
            end
            S_CLEAR: begin
                we_d   = 1'b1;
                addr_d = clr_q;
                data_d = fill_q;
                if (clr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            write_enable <= 1'b0;
            address_wr   <= '0;
            data_in      <= '0;
            cursor_row   <= '0;
            cursor_col   <= '0;
            fill_q       <= '0;
            clr_q        <= '0;
        end else begin
            state        <= state_d;
            write_enable <= we_d;
            address_wr   <= addr_d;
            data_in      <= data_d;
            cursor_row   <= row_d;
            cursor_col   <= col_d;
            fill_q       <= fill_d;
            clr_q        <= clr_d;
        end
    end

    // RAM enable comes up on the first edge after reset and stays on
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enable_ram <= 1'b0;
        end else begin
            enable_ram <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phrase_writer.sv
// tb_phrase_writer: directed stimulus against a linear-position model of the
// phrase writer, with per-cycle output comparison and hand-computed checks.
module tb_phrase_writer;

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int TOTAL = COLS * ROWS;

    logic        clock;
    logic        reset;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [12:0] cmd_data;
    logic        cmd_ready;
    logic        enable_ram;
    logic        write_enable;
    logic [12:0] address_wr;
    logic [7:0]  data_in;
    logic        busy;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;

    phrase_writer #(.COLS(80), .ROWS(60), .COL_W(7), .ROW_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .enable_ram   (enable_ram),
        .write_enable (write_enable),
        .address_wr   (address_wr),
        .data_in      (data_in),
        .busy         (busy),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cursor kept as a linear screen position, clear as a remaining count
    int         m_pos  = 0;
    int         m_rem  = 0;
    int         m_addr = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_fill = 8'h00;
    bit         m_we   = 1'b0;
    bit         m_en   = 1'b0;
    bit         m_acc  = 1'b0;
    int         m_r, m_c;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_pos = 0; m_rem = 0; m_addr = 0; m_data = 8'h00;
            m_fill = 8'h00; m_we = 1'b0; m_en = 1'b0; m_acc = 1'b0;
        end else begin
            m_en  = 1'b1;
            m_we  = 1'b0;
            m_acc = cmd_valid && (m_rem == 0);
            if (m_acc) begin
                case (cmd_op)
                    2'b01: begin
`ifdef PHRASE_NEWLINE_EN
                        if (cmd_data[7:0] == 8'h0A)
                            m_pos = (((m_pos / COLS) + 1) % ROWS) * COLS;
                        else begin
`else
                        begin
`endif
                            m_we   = 1'b1;
                            m_addr = m_pos;
                            m_data = cmd_data[7:0];
                            m_pos  = (m_pos + 1) % TOTAL;
                        end
                    end
                    2'b10: begin
                        m_r = int'(cmd_data[12:7]);
                        m_c = int'(cmd_data[6:0]);
                        if (m_r < ROWS && m_c < COLS) m_pos = m_r * COLS + m_c;
                    end
                    2'b11: begin
                        m_fill = cmd_data[7:0];
                        m_rem  = TOTAL;
                    end
                    default: ;
                endcase
            end
            if (m_rem > 0) begin
                m_we   = 1'b1;
                m_addr = TOTAL - m_rem;
                m_data = m_fill;
                m_rem  = m_rem - 1;
                if (m_rem == 0) m_pos = 0;
            end
        end
    end

    // Compare process plus write/busy counters for the clear checks
    int wr20_n = 0;
    int busy_n = 0;

    initial forever begin
        @(negedge clock);
        chk("enable_ram",   32'(enable_ram),   32'(m_en));
        chk("cmd_ready",    32'(cmd_ready),    32'(!reset && m_rem == 0));
        chk("busy",         32'(busy),         32'(m_rem > 0));
        chk("write_enable", 32'(write_enable), 32'(m_we));
        chk("address_wr",   32'(address_wr),   m_addr);
        chk("data_in",      32'(data_in),      32'(m_data));
        chk("cursor_row",   32'(cursor_row),   m_pos / COLS);
        chk("cursor_col",   32'(cursor_col),   m_pos % COLS);
        if (write_enable === 1'b1 && data_in === 8'h20) wr20_n++;
        if (busy === 1'b1) busy_n++;
    end

    // Present a command and hold it until the model reports acceptance
    task automatic send(input logic [1:0] op, input logic [12:0] data);
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        for (int i = 0; i < 10000 && !done; i++) begin
            @(negedge clock);
            if (m_acc) done = 1'b1;
        end
        if (!done) chk("send_timeout", 32'(0), 32'(1));
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
    endtask

    function automatic logic [12:0] rc(input int r, input int c);
        logic [5:0] rr = 6'(r);
        logic [6:0] cc = 7'(c);
        return {rr, cc};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_en",    32'(enable_ram), 0);
        chk("rst_addr",  32'(address_wr), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_en",    32'(enable_ram), 1);
        chk("post_rst_ready", 32'(cmd_ready), 1);

        // First character at home position
        send(2'b01, 13'h041);
        chk("w41_we",   32'(write_enable), 1);
        chk("w41_addr", 32'(address_wr), 0);
        chk("w41_data", 32'(data_in), 32'h41);
        chk("w41_col",  32'(cursor_col), 1);
        @(negedge clock);
        chk("w41_we_drop", 32'(write_enable), 0);

        // Last cell then wrap to 0
        send(2'b10, rc(59, 79));
        chk("set_row", 32'(cursor_row), 59);
        chk("set_col", 32'(cursor_col), 79);
        send(2'b01, 13'h042);
        chk("w42_addr",  32'(address_wr), 4799);
        chk("model_w42", m_addr, 4799);
        send(2'b01, 13'h043);
        chk("w43_we",   32'(write_enable), 1);
        chk("w43_addr", 32'(address_wr), 0);
        chk("w43_row",  32'(cursor_row), 0);
        chk("w43_col",  32'(cursor_col), 1);

        // Out-of-range cursor is ignored
        send(2'b10, rc(60, 0));
        chk("bad_set_we",  32'(write_enable), 0);
        chk("bad_set_row", 32'(cursor_row), 0);
        chk("bad_set_col", 32'(cursor_col), 1);

        // Newline character
        send(2'b10, rc(3, 10));
        send(2'b01, 13'h00A);
`ifdef PHRASE_NEWLINE_EN
        chk("nl_we",  32'(write_enable), 0);
        chk("nl_row", 32'(cursor_row), 4);
        chk("nl_col", 32'(cursor_col), 0);
`else
        chk("nl_we",   32'(write_enable), 1);
        chk("nl_addr", 32'(address_wr), 250);
        chk("nl_data", 32'(data_in), 32'h0A);
        chk("nl_col",  32'(cursor_col), 11);
`endif

        // Back-to-back writes at consecutive addresses
        send(2'b10, rc(10, 78));
        send(2'b01, 13'h061);
        chk("b2b0_addr", 32'(address_wr), 878);
        send(2'b01, 13'h062);
        chk("b2b1_addr", 32'(address_wr), 879);
        send(2'b01, 13'h063);
        chk("b2b2_addr", 32'(address_wr), 880);
        chk("b2b2_row",  32'(cursor_row), 11);
        chk("b2b2_col",  32'(cursor_col), 1);

        // Full clear with a command held behind it
        wr20_n = 0;
        busy_n = 0;
        send(2'b11, 13'h020);
        chk("clr_first_addr", 32'(address_wr), 0);
        chk("clr_ready_low",  32'(cmd_ready), 0);
        send(2'b01, 13'h055);
        chk("clr_writes",     wr20_n, 4800);
        chk("clr_busy_cyc",   busy_n, 4799);
        chk("held_addr",      32'(address_wr), 0);
        chk("held_data",      32'(data_in), 32'h55);
        chk("held_col",       32'(cursor_col), 1);

        // Reset in the middle of a clear
        send(2'b11, 13'h02A);
        repeat (1000) @(negedge clock);
        chk("mid_clr_addr", 32'(address_wr), 1000);
        chk("mid_clr_busy", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_we",    32'(write_enable), 0);
        chk("abort_addr",  32'(address_wr), 0);
        chk("abort_data",  32'(data_in), 0);
        chk("abort_busy",  32'(busy), 0);
        chk("abort_ready", 32'(cmd_ready), 0);
        chk("abort_en",    32'(enable_ram), 0);
        chk("abort_col",   32'(cursor_col), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rerel_ready", 32'(cmd_ready), 1);
        chk("rerel_en",    32'(enable_ram), 1);
        send(2'b01, 13'h07A);
        chk("rerel_addr", 32'(address_wr), 0);
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
